// File: rtl/lsu_pkg.sv
// lsu_pkg: shared memop encodings, FSM state type and access-size helpers
// for the load/store unit.
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_LO  = 3'd1,
    WAIT_LO = 3'd2,
    REQ_HI  = 3'd3,
    WAIT_HI = 3'd4,
    RESP    = 3'd5
  } lsu_state_t;

  // Takes memop[1:0]: 00 byte, 01 half, anything else word.
  function automatic logic [3:0] base_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] access_size(input logic [1:0] sz);
    case (sz)
      2'b00:   access_size = 3'd1;
      2'b01:   access_size = 3'd2;
      default: access_size = 3'd4;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic - store data/mask placement for the low
// and high word of an access, and load extraction with sign/zero extension.
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  memop,
  input  logic [31:0] wdata,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  input  logic        split,
  output logic [31:0] lo_wdata,
  output logic [3:0]  lo_wmask,
  output logic [31:0] hi_wdata,
  output logic [3:0]  hi_wmask,
  output logic [31:0] rdata
);

  logic [3:0]  bmask;
  logic [4:0]  lo_sh;
  logic [5:0]  hi_sh;
  logic [2:0]  hi_msh;
  logic [63:0] pair;
  logic [31:0] window;

  always_comb begin
    bmask    = base_mask(memop[1:0]);
    lo_sh    = {off, 3'b000};
    // off == 0 gives a 32-bit / 4-lane shift, which empties the high word
    hi_sh    = 6'd32 - {1'b0, off, 3'b000};
    hi_msh   = 3'd4 - {1'b0, off};
    lo_wdata = wdata << lo_sh;
    lo_wmask = bmask << off;
    hi_wdata = wdata >> hi_sh;
    hi_wmask = bmask >> hi_msh;

    pair     = {(split ? hi_word : 32'h0), lo_word};
    window   = 32'(pair >> lo_sh);
    case (memop)
      MEMOP_B:  rdata = {{24{window[7]}}, window[7:0]};
      MEMOP_BU: rdata = {24'h0, window[7:0]};
      MEMOP_H:  rdata = {{16{window[15]}}, window[15:0]};
      MEMOP_HU: rdata = {16'h0, window[15:0]};
      default:  rdata = window;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
// lsu: load/store unit FSM. Takes one operation from execute, issues one or
// two aligned memory requests, and returns extended load data or completion.
`default_nettype none

module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic            in_wen,
  input  logic            in_ren,
  input  logic [2:0]      in_memop,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  output logic            mem_req_wen,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [3:0]      mem_req_wmask,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rdata,
  output logic            out_err
);

  lsu_state_t  state;
  logic [29:0] word_addr;
  logic [1:0]  off;
  logic [2:0]  memop;
  logic [31:0] wdata;
  logic        wen;
  logic        split;
  logic [31:0] lo_word;
  logic [31:0] hi_word;

  logic        idle;
  logic [1:0]  a_off;
  logic [2:0]  a_memop;
  logic [31:0] a_wdata;
  logic [31:0] a_lo;
  logic [31:0] a_hi;
  logic [31:0] lo_wdata;
  logic [3:0]  lo_wmask;
  logic [31:0] hi_wdata;
  logic [3:0]  hi_wmask;
  logic [31:0] ext_rdata;

  logic        illegal;
  logic        in_split;
  logic [2:0]  in_size;

  assign idle     = (state == IDLE);
  assign in_ready = idle;

  // In IDLE the lane logic sees the incoming op so the first request can be
  // registered on the accept edge; afterwards it sees the latched op.
  assign a_off   = idle ? in_addr[1:0] : off;
  assign a_memop = idle ? in_memop     : memop;
  assign a_wdata = idle ? in_wdata     : wdata;
  assign a_lo    = (state == WAIT_LO) ? mem_resp_rdata : lo_word;
  assign a_hi    = (state == WAIT_HI) ? mem_resp_rdata : hi_word;

  always_comb begin
    illegal  = (in_memop == 3'b011) || (in_memop[2:1] == 2'b11) ||
               (in_wen && in_memop[2]) || (in_wen && in_ren);
    in_size  = access_size(in_memop[1:0]);
    in_split = ({1'b0, in_addr[1:0]} + in_size) > 3'd4;
  end

  lsu_align u_align (
    .off      (a_off),
    .memop    (a_memop),
    .wdata    (a_wdata),
    .lo_word  (a_lo),
    .hi_word  (a_hi),
    .split    (split),
    .lo_wdata (lo_wdata),
    .lo_wmask (lo_wmask),
    .hi_wdata (hi_wdata),
    .hi_wmask (hi_wmask),
    .rdata    (ext_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      word_addr     <= '0;
      off           <= '0;
      memop         <= '0;
      wdata         <= '0;
      wen           <= 1'b0;
      split         <= 1'b0;
      lo_word       <= '0;
      hi_word       <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      out_valid     <= 1'b0;
      out_rdata     <= '0;
      out_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word_addr <= in_addr[31:2];
            off       <= in_addr[1:0];
            memop     <= in_memop;
            wdata     <= in_wdata;
            wen       <= in_wen;
            split     <= in_split;
            if (illegal || (!in_wen && !in_ren)) begin
              state     <= RESP;
              out_valid <= 1'b1;
              out_err   <= illegal;
              out_rdata <= '0;
            end else begin
              state         <= REQ_LO;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {in_addr[31:2], 2'b00};
              mem_req_wen   <= in_wen;
              mem_req_wdata <= in_wen ? lo_wdata : 32'h0;
              mem_req_wmask <= in_wen ? lo_wmask : 4'h0;
            end
          end
        end
        REQ_LO: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (mem_resp_valid) begin
            lo_word <= mem_resp_rdata;
            if (split) begin
              state         <= REQ_HI;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {word_addr + 30'd1, 2'b00};
              mem_req_wdata <= wen ? hi_wdata : 32'h0;
              mem_req_wmask <= wen ? hi_wmask : 4'h0;
            end else begin
              state     <= RESP;
              out_valid <= 1'b1;
              out_err   <= 1'b0;
              out_rdata <= wen ? 32'h0 : ext_rdata;
            end
          end
        end
        REQ_HI: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (mem_resp_valid) begin
            hi_word   <= mem_resp_rdata;
            state     <= RESP;
            out_valid <= 1'b1;
            out_err   <= 1'b0;
            out_rdata <= wen ? 32'h0 : ext_rdata;
          end
        end
        RESP: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_rdata <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// tb_lsu: directed table-driven bench for lsu with a small responding memory,
// plus hand sequences for stalls and mid-transaction reset.
`default_nettype none
`timescale 1ns/1ps

module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = 32'h0;
  logic [31:0] in_wdata = 32'h0;
  logic        in_wen = 1'b0;
  logic        in_ren = 1'b0;
  logic [2:0]  in_memop = 3'b000;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rdata;
  logic        out_err;

  always #5 clk = ~clk;

  lsu dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_addr        (in_addr),
    .in_wdata       (in_wdata),
    .in_wen         (in_wen),
    .in_ren         (in_ren),
    .in_memop       (in_memop),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wen    (mem_req_wen),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_rdata      (out_rdata),
    .out_err        (out_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic        ren;
    logic [2:0]  memop;
    logic [31:0] lo;
    logic [31:0] hi;
    int          waitc;
    int          nreq;
    logic [31:0] a0;
    logic [3:0]  m0;
    logic [31:0] d0;
    logic [31:0] a1;
    logic [3:0]  m1;
    logic [31:0] d1;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input int rstall, input int ostall, input string tag);
    logic [31:0] ra[2];
    logic [3:0]  rm[2];
    logic [31:0] rd[2];
    logic        rw[2];
    logic [31:0] snap_a, snap_d, hold_r;
    logic [3:0]  snap_m;
    logic        hold_e;
    bit          snapped, done;
    int          nreq, cnt, cyc, stall;
    for (int i = 0; i < 2; i++) begin
      ra[i] = 'x; rm[i] = 'x; rd[i] = 'x; rw[i] = 1'bx;
    end
    snap_a = '0; snap_d = '0; snap_m = '0;
    @(negedge clk);
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    chk($sformatf("%s in_ready_idle", tag), {31'h0, in_ready}, 32'h1);
    in_valid = 1'b1; in_addr = v.addr; in_wdata = v.wdata;
    in_wen = v.wen; in_ren = v.ren; in_memop = v.memop;
    @(negedge clk);
    in_valid = 1'b0; in_addr = 32'h0; in_wdata = 32'h0; in_wen = 1'b0; in_ren = 1'b0;
    cyc = 1; nreq = 0; cnt = -1; stall = rstall; done = 0; snapped = 0;
    while (!done && cyc < 100) begin
      mem_resp_valid = 1'b0;
      if (cnt == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = (nreq == 1) ? v.lo : v.hi;
        cnt = -1;
      end else if (cnt > 0) begin
        cnt--;
      end
      mem_req_ready = 1'b1;
      if (mem_req_valid) begin
        if (!snapped) begin
          snap_a = mem_req_addr; snap_d = mem_req_wdata; snap_m = mem_req_wmask; snapped = 1;
        end
        if (stall > 0) begin
          mem_req_ready = 1'b0;
          stall--;
        end else begin
          chk($sformatf("%s req_stable", tag), {mem_req_addr ^ snap_a} | {mem_req_wdata ^ snap_d} |
              {28'h0, mem_req_wmask ^ snap_m}, 32'h0);
          if (nreq < 2) begin
            ra[nreq] = mem_req_addr; rm[nreq] = mem_req_wmask;
            rd[nreq] = mem_req_wdata; rw[nreq] = mem_req_wen;
          end
          nreq++; cnt = v.waitc; snapped = 0; stall = rstall;
        end
      end
      if (out_valid) begin
        mem_resp_valid = 1'b0;
        mem_req_ready = 1'b1;
        if (v.lat != 0) chk($sformatf("%s latency", tag), cyc, v.lat);
        chk($sformatf("%s rdata", tag), out_rdata, v.rdata);
        chk($sformatf("%s err", tag), {31'h0, out_err}, {31'h0, v.err});
        chk($sformatf("%s nreq", tag), nreq, v.nreq);
        chk($sformatf("%s in_ready_busy", tag), {31'h0, in_ready}, 32'h0);
        if (v.nreq >= 1) begin
          chk($sformatf("%s req0_addr", tag), ra[0], v.a0);
          chk($sformatf("%s req0_mask", tag), {28'h0, rm[0]}, {28'h0, v.m0});
          chk($sformatf("%s req0_wdata", tag), rd[0], v.d0);
          chk($sformatf("%s req0_wen", tag), {31'h0, rw[0]}, {31'h0, v.wen});
        end
        if (v.nreq == 2) begin
          chk($sformatf("%s req1_addr", tag), ra[1], v.a1);
          chk($sformatf("%s req1_mask", tag), {28'h0, rm[1]}, {28'h0, v.m1});
          chk($sformatf("%s req1_wdata", tag), rd[1], v.d1);
        end
        hold_r = out_rdata; hold_e = out_err;
        for (int k = 0; k < ostall; k++) begin
          out_ready = 1'b0;
          @(negedge clk);
          chk($sformatf("%s out_hold", tag),
              {30'h0, out_valid, (out_err ^ hold_e)} | (out_rdata ^ hold_r), 32'h2);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk($sformatf("%s after_out", tag), {30'h0, out_valid, in_ready}, 32'h1);
        done = 1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    mem_resp_valid = 1'b0;
    mem_req_ready = 1'b1;
    if (!done) begin
      errors++; checks++;
      $display("FAIL %s timeout: got no out_valid expected one within 100 cycles", tag);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk($sformatf("%s in_ready", tag), {31'h0, in_ready}, 32'h1);
    chk($sformatf("%s req_valid", tag), {31'h0, mem_req_valid}, 32'h0);
    chk($sformatf("%s req_addr", tag), mem_req_addr, 32'h0);
    chk($sformatf("%s req_wen", tag), {31'h0, mem_req_wen}, 32'h0);
    chk($sformatf("%s req_wdata", tag), mem_req_wdata, 32'h0);
    chk($sformatf("%s req_wmask", tag), {28'h0, mem_req_wmask}, 32'h0);
    chk($sformatf("%s out_valid", tag), {31'h0, out_valid}, 32'h0);
    chk($sformatf("%s out_rdata", tag), out_rdata, 32'h0);
    chk($sformatf("%s out_err", tag), {31'h0, out_err}, 32'h0);
  endtask

  initial begin
    vec_t sv;
    //          addr          wdata         wen   ren   memop    lo            hi            w  n  a0            m0     d0            a1            m1     d1            rdata         err   lat
    vecs[0]  = '{32'h80000004, 32'h0,        1'b0, 1'b1, MEMOP_W, 32'hDEADBEEF, 32'h0,        2, 1, 32'h80000004, 4'h0,  32'h0,        32'h0,        4'h0,  32'h0,        32'hDEADBEEF, 1'b0, 5};
    vecs[1]  = '{32'h80000003, 32'h0,        1'b0, 1'b1, MEMOP_B, 32'h80FF1234, 32'h0,        0, 1, 32'h80000000, 4'h0,  32'h0,        32'h0,        4'h0,  32'h0,        32'hFFFFFF80, 1'b0, 3};
    vecs[2]  = '{32'h80000003, 32'h0,        1'b0, 1'b1, MEMOP_BU,32'h80FF1234, 32'h0,        0, 1, 32'h80000000, 4'h0,  32'h0,        32'h0,        4'h0,  32'h0,        32'h00000080, 1'b0, 3};
    vecs[3]  = '{32'h80000003, 32'h0000ABCD, 1'b1, 1'b0, MEMOP_H, 32'h0,        32'h0,        0, 2, 32'h80000000, 4'h8,  32'hCD000000, 32'h80000004, 4'h1,  32'h000000AB, 32'h0,        1'b0, 5};
    vecs[4]  = '{32'h80000002, 32'h0,        1'b0, 1'b1, MEMOP_W, 32'h11223344, 32'h55667788, 0, 2, 32'h80000000, 4'h0,  32'h0,        32'h80000004, 4'h0,  32'h0,        32'h77881122, 1'b0, 5};
    vecs[5]  = '{32'h80000000, 32'h0,        1'b0, 1'b1, 3'b110,  32'h0,        32'h0,        0, 0, 32'h0,        4'h0,  32'h0,        32'h0,        4'h0,  32'h0,        32'h0,        1'b1, 1};
    vecs[6]  = '{32'h80000000, 32'h12345678, 1'b1, 1'b0, 3'b100,  32'h0,        32'h0,        0, 0, 32'h0,        4'h0,  32'h0,        32'h0,        4'h0,  32'h0,        32'h0,        1'b1, 1};
    vecs[7]  = '{32'h80000000, 32'h12345678, 1'b1, 1'b1, MEMOP_W, 32'h0,        32'h0,        0, 0, 32'h0,        4'h0,  32'h0,        32'h0,        4'h0,  32'h0,        32'h0,        1'b1, 1};
    vecs[8]  = '{32'h80000000, 32'h12345678, 1'b0, 1'b0, MEMOP_W, 32'h0,        32'h0,        0, 0, 32'h0,        4'h0,  32'h0,        32'h0,        4'h0,  32'h0,        32'h0,        1'b0, 1};
    vecs[9]  = '{32'h10000000, 32'h12345678, 1'b1, 1'b0, MEMOP_W, 32'h0,        32'h0,        0, 1, 32'h10000000, 4'hF,  32'h12345678, 32'h0,        4'h0,  32'h0,        32'h0,        1'b0, 3};
    vecs[10] = '{32'h10000002, 32'h0,        1'b0, 1'b1, MEMOP_HU,32'hBEEF1234, 32'h0,        1, 1, 32'h10000000, 4'h0,  32'h0,        32'h0,        4'h0,  32'h0,        32'h0000BEEF, 1'b0, 4};
    vecs[11] = '{32'h10000002, 32'h0,        1'b0, 1'b1, MEMOP_H, 32'hBEEF1234, 32'h0,        0, 1, 32'h10000000, 4'h0,  32'h0,        32'h0,        4'h0,  32'h0,        32'hFFFFBEEF, 1'b0, 3};
    vecs[12] = '{32'h20000001, 32'h000000A5, 1'b1, 1'b0, MEMOP_B, 32'h0,        32'h0,        0, 1, 32'h20000000, 4'h2,  32'h0000A500, 32'h0,        4'h0,  32'h0,        32'h0,        1'b0, 3};
    vecs[13] = '{32'h20000002, 32'h00001234, 1'b1, 1'b0, MEMOP_H, 32'h0,        32'h0,        0, 1, 32'h20000000, 4'hC,  32'h12340000, 32'h0,        4'h0,  32'h0,        32'h0,        1'b0, 3};
    vecs[14] = '{32'hFFFFFFFF, 32'h0,        1'b0, 1'b1, MEMOP_H, 32'h01020304, 32'h000000F0, 0, 2, 32'hFFFFFFFC, 4'h0,  32'h0,        32'h00000000, 4'h0,  32'h0,        32'hFFFFF001, 1'b0, 5};
    vecs[15] = '{32'h00000001, 32'hAABBCCDD, 1'b1, 1'b0, MEMOP_W, 32'h0,        32'h0,        0, 2, 32'h00000000, 4'hE,  32'hBBCCDD00, 32'h00000004, 4'h1,  32'h000000AA, 32'h0,        1'b0, 5};
    vecs[16] = '{32'h80000000, 32'h0,        1'b0, 1'b1, 3'b011,  32'h0,        32'h0,        0, 0, 32'h0,        4'h0,  32'h0,        32'h0,        4'h0,  32'h0,        32'h0,        1'b1, 1};

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;

    for (int i = 0; i < 17; i++) run_op(vecs[i], 0, 0, $sformatf("vec%0d", i));

    // Request-side and result-side backpressure on a split store
    sv = vecs[3];
    sv.lat = 0;
    run_op(sv, 3, 4, "stall_split_store");

    // Reset while waiting for the low response, then a stray late response
    @(negedge clk);
    in_valid = 1'b1; in_addr = 32'h00000100; in_wen = 1'b0; in_ren = 1'b1; in_memop = MEMOP_W;
    mem_req_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_seq req_valid", {31'h0, mem_req_valid}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst_async");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst_stray");
    run_op(vecs[0], 0, 0, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
